// File: rtl/mul_acc_fp_lanes.sv
// Multi-lane minifloat multiply-accumulate: exact lane products, adder tree and
// optional block accumulation behind a three-stage valid/ready pipeline.
module mul_acc_fp_lanes #(
  parameter int EXP_WIDTH = 4,
  parameter int MAN_WIDTH = 3,
  parameter int BIT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH,
  parameter int LANES     = 4,
  parameter int BLOCK_LEN = 8,
  parameter int PRD_WIDTH = 2 * ((1 << EXP_WIDTH) + MAN_WIDTH),
  parameter int ACC_WIDTH = PRD_WIDTH + $clog2(LANES) + $clog2(BLOCK_LEN) + 1,
  parameter int CNT_WIDTH = $clog2(BLOCK_LEN + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*BIT_WIDTH-1:0] i_op0,
  input  logic [LANES*BIT_WIDTH-1:0] i_op1,
  input  logic                       i_mode,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [ACC_WIDTH-1:0]       o_acc,
  output logic [CNT_WIDTH-1:0]       o_beats
);

  localparam int SM_W  = (EXP_WIDTH == 0) ? BIT_WIDTH : MAN_WIDTH + 2;
  localparam int MP_W  = 2 * SM_W;
  localparam int SH_W  = (EXP_WIDTH == 0) ? 1 : EXP_WIDTH + 1;
  localparam int SUM_W = PRD_WIDTH + $clog2(LANES);

  logic                    w_stall;
  logic                    w_accept;
  logic                    w_first;
  logic                    w_mode;
  logic                    w_close;
  logic [CNT_WIDTH-1:0]    w_cnt;
  logic signed [SM_W-1:0]  w_sm0 [LANES];
  logic signed [SM_W-1:0]  w_sm1 [LANES];
  logic [SH_W-1:0]         w_sh [LANES];
  logic signed [MP_W-1:0]  w_mprd [LANES];
  logic signed [PRD_WIDTH-1:0] w_leaf [LANES];
  logic signed [SUM_W-1:0] w_node [2*LANES-1];
  logic [ACC_WIDTH-1:0]    w_acc_next;

  logic                    r_blk_open;
  logic                    r_blk_mode;
  logic [CNT_WIDTH-1:0]    r_blk_cnt;

  logic                    r_s1_valid;
  logic                    r_s1_first;
  logic                    r_s1_last;
  logic [CNT_WIDTH-1:0]    r_s1_cnt;
  logic signed [MP_W-1:0]  r_s1_mprd [LANES];
  logic [SH_W-1:0]         r_s1_sh [LANES];

  logic                    r_s2_valid;
  logic                    r_s2_first;
  logic                    r_s2_last;
  logic [CNT_WIDTH-1:0]    r_s2_cnt;
  logic signed [SUM_W-1:0] r_s2_sum;

  logic [ACC_WIDTH-1:0]    r_acc;
  logic                    r_out_valid;
  logic [ACC_WIDTH-1:0]    r_out_acc;
  logic [CNT_WIDTH-1:0]    r_out_beats;

  assign w_stall  = r_out_valid && !i_ready;
  assign w_accept = i_valid && !w_stall;
  assign o_ready  = !w_stall;
  assign o_valid  = r_out_valid;
  assign o_acc    = r_out_acc;
  assign o_beats  = r_out_beats;

  // Block framing is resolved at the input so every beat carries its own tags.
  assign w_first = !r_blk_open;
  assign w_mode  = r_blk_open ? r_blk_mode : i_mode;
  assign w_cnt   = r_blk_open ? r_blk_cnt + CNT_WIDTH'(1) : CNT_WIDTH'(1);
  assign w_close = !w_mode || i_last || (w_cnt == CNT_WIDTH'(BLOCK_LEN));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BIT_WIDTH-1:0] w_a;
    logic [BIT_WIDTH-1:0] w_b;
    assign w_a = i_op0[gi*BIT_WIDTH +: BIT_WIDTH];
    assign w_b = i_op1[gi*BIT_WIDTH +: BIT_WIDTH];

    if (EXP_WIDTH > 0) begin : g_fp
      logic [EXP_WIDTH-1:0] w_ea;
      logic [EXP_WIDTH-1:0] w_eb;
      logic                 w_na;
      logic                 w_nb;
      logic [MAN_WIDTH:0]   w_ma;
      logic [MAN_WIDTH:0]   w_mb;
      assign w_ea = w_a[BIT_WIDTH-2 -: EXP_WIDTH];
      assign w_eb = w_b[BIT_WIDTH-2 -: EXP_WIDTH];
      assign w_na = |w_ea;
      assign w_nb = |w_eb;
      assign w_ma = {w_na, w_a[MAN_WIDTH-1:0]};
      assign w_mb = {w_nb, w_b[MAN_WIDTH-1:0]};
      assign w_sm0[gi] = w_a[BIT_WIDTH-1] ? -SM_W'(w_ma) : SM_W'(w_ma);
      assign w_sm1[gi] = w_b[BIT_WIDTH-1] ? -SM_W'(w_mb) : SM_W'(w_mb);
      // Subnormals (e=0) and the smallest normals both land on shift 0.
      assign w_sh[gi] = SH_W'(w_ea - EXP_WIDTH'(w_na)) + SH_W'(w_eb - EXP_WIDTH'(w_nb));
    end else begin : g_int
      assign w_sm0[gi] = w_a;
      assign w_sm1[gi] = w_b;
      assign w_sh[gi]  = '0;
    end

    assign w_mprd[gi] = MP_W'(w_sm0[gi]) * MP_W'(w_sm1[gi]);
    assign w_leaf[gi] = PRD_WIDTH'(r_s1_mprd[gi]) <<< r_s1_sh[gi];
  end

  // Heap-ordered adder tree: leaves at LANES-1.., node k sums children 2k+1, 2k+2.
  always_comb begin
    for (int k = 0; k < 2*LANES-1; k++) begin
      w_node[k] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      w_node[LANES-1+k] = SUM_W'(w_leaf[k]);
    end
    for (int k = LANES-2; k >= 0; k--) begin
      w_node[k] = w_node[2*k+1] + w_node[2*k+2];
    end
  end

  assign w_acc_next = r_s2_first ? ACC_WIDTH'(r_s2_sum) : r_acc + ACC_WIDTH'(r_s2_sum);

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int k = 0; k < LANES; k++) begin
        r_s1_mprd[k] <= w_mprd[k];
        r_s1_sh[k]   <= w_sh[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blk_open  <= 1'b0;
      r_blk_mode  <= 1'b0;
      r_blk_cnt   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_cnt    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_first  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_cnt    <= '0;
      r_s2_sum    <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_beats <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_close;
        r_s1_cnt   <= w_cnt;
        r_blk_open <= !w_close;
        r_blk_mode <= w_mode;
        r_blk_cnt  <= w_cnt;
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_cnt   <= r_s1_cnt;
        r_s2_sum   <= w_node[0];
      end

      // Not stalled means any held result is being taken this cycle.
      r_out_valid <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
        if (r_s2_last) begin
          r_out_acc   <= w_acc_next;
          r_out_beats <= r_s2_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_acc_fp_lanes.sv
// Bench for mul_acc_fp_lanes (E4M3, 4 lanes, blocks of 8): a value-level model
// fills a scoreboard at accept time and results are compared as they leave.
module tb_mul_acc_fp_lanes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_op0;
  logic [31:0] i_op1;
  logic        i_mode;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [43:0] o_acc;
  logic [3:0]  o_beats;

  mul_acc_fp_lanes dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op0   (i_op0),
    .i_op1   (i_op1),
    .i_mode  (i_mode),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_acc   (o_acc),
    .o_beats (o_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint acc;
    int     beats;
    int     cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     n_results = 0;
  longint last_acc = 0;
  int     last_beats = 0;
  int     last_lat = 0;
  bit     rand_ready = 0;
  bit     m_open = 0;
  bit     m_mode = 0;
  int     m_cnt = 0;
  longint m_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  // Element value in units of the smallest subnormal: normals (8+m)*2^(e-1), subnormals m.
  function automatic longint elem_val(input logic [7:0] x);
    int     e;
    int     m;
    longint mag;
    e = int'(x[6:3]);
    m = int'(x[2:0]);
    if (e == 0) mag = longint'(m);
    else mag = longint'(8 + m) << (e - 1);
    return x[7] ? -mag : mag;
  endfunction

  function automatic longint beat_sum(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = 0;
    for (int k = 0; k < 4; k++) s += elem_val(a[k*8 +: 8]) * elem_val(b[k*8 +: 8]);
    return s;
  endfunction

  // Monitor: at each negedge, decide what the next posedge transfers.
  initial begin
    exp_t   ex;
    longint s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        m_open = 0;
        m_mode = 0;
        m_cnt  = 0;
        m_acc  = 0;
      end else begin
        if (o_valid && i_ready) begin
          n_results++;
          last_acc   = longint'($signed(o_acc));
          last_beats = int'(o_beats);
          $display("result acc=%0d beats=%0d cyc=%0d", last_acc, last_beats, cyc);
          if (sb_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            ex = sb_q.pop_front();
            check("acc", last_acc, ex.acc);
            check("beats", longint'(last_beats), longint'(ex.beats));
            last_lat = cyc - ex.cyc;
          end
        end
        if (i_valid && o_ready) begin
          s = beat_sum(i_op0, i_op1);
          if (!m_open) begin
            m_mode = i_mode;
            m_cnt  = 1;
            m_acc  = s;
          end else begin
            m_cnt++;
            m_acc += s;
          end
          if (!m_mode || i_last || m_cnt == 8) begin
            ex.acc   = m_acc;
            ex.beats = m_cnt;
            ex.cyc   = cyc;
            sb_q.push_back(ex);
            m_open = 0;
          end else begin
            m_open = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic mode, input logic last);
    bit ok;
    int guard;
    ok = 0;
    guard = 0;
    i_op0 = a;
    i_op1 = b;
    i_mode = mode;
    i_last = last;
    i_valid = 1'b1;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    i_valid = 1'b0;
    while (sb_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (sb_q.size() != 0) check("drain_timeout", longint'(sb_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rc;
    logic [43:0] held;
    i_valid = 1'b0;
    i_op0 = '0;
    i_op1 = '0;
    i_mode = 1'b0;
    i_last = 1'b0;
    i_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_valid", longint'(o_valid), 0);
    check("rst_acc", longint'(o_acc), 0);
    check("rst_beats", longint'(o_beats), 0);
    check("rst_ready", longint'(o_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Mode 0, every lane 1.0 * 1.0
    send({4{8'h38}}, {4{8'h38}}, 1'b0, 1'b0);
    drain();
    check("t1_acc", last_acc, 1048576);
    check("t1_beats", longint'(last_beats), 1);
    check("t1_latency", longint'(last_lat), 3);

    // Mode 0, subnormal product plus a negative normal product
    send({8'h00, 8'h00, 8'hB8, 8'h01}, {8'h00, 8'h00, 8'h38, 8'h01}, 1'b0, 1'b1);
    drain();
    check("t2_acc", last_acc, -262143);
    check("t2_latency", longint'(last_lat), 3);

    // Mode 1, full block of 8 without i_last
    rc = n_results;
    for (int i = 0; i < 7; i++) send({24'h0, 8'h38}, {24'h0, 8'h38}, 1'b1, 1'b0);
    idle(8);
    check("t3_early", longint'(n_results - rc), 0);
    send({24'h0, 8'h38}, {24'h0, 8'h38}, 1'b1, 1'b0);
    drain();
    check("t3_count", longint'(n_results - rc), 1);
    check("t3_acc", last_acc, 2097152);
    check("t3_beats", longint'(last_beats), 8);

    // Mode 1, early close at 3 (mid-block mode flip ignored), then a block of 2
    rc = n_results;
    send({24'h0, 8'h40}, {24'h0, 8'h38}, 1'b1, 1'b0);
    send({24'h0, 8'h38}, {24'h0, 8'hC0}, 1'b0, 1'b0);
    send({16'h0, 8'h01, 8'h00}, {16'h0, 8'h7F, 8'h00}, 1'b1, 1'b1);
    send({24'h0, 8'h38}, {24'h0, 8'h38}, 1'b1, 1'b0);
    send({24'h0, 8'h38}, {24'h0, 8'h38}, 1'b1, 1'b1);
    drain();
    check("t4_count", longint'(n_results - rc), 2);
    check("t4_acc", last_acc, 524288);
    check("t4_beats", longint'(last_beats), 2);

    // Downstream stall for 5 cycles under a continuous mode-0 stream
    rc = n_results;
    fork
      begin
        for (int i = 0; i < 12; i++) send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        i_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 i_ready = 1'b0;
        @(negedge clk);
        held = o_acc;
        check("stall_valid", longint'(o_valid), 1);
        check("stall_ready", longint'(o_ready), 0);
        repeat (4) begin
          @(negedge clk);
          check("stall_ready", longint'(o_ready), 0);
          check("stall_hold", longint'(o_acc), longint'(held));
        end
        @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    check("t5_count", longint'(n_results - rc), 12);

    // Random mix of modes, last flags, gaps and backpressure
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rand_ready = 0;
    @(posedge clk);
    #2 i_ready = 1'b1;
    send(32'h0, 32'h0, 1'b1, 1'b1);
    drain();

    // Asynchronous reset in the middle of a mode-1 block
    send({24'h0, 8'h38}, {24'h0, 8'h38}, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) send({24'h0, 8'h38}, {24'h0, 8'h38}, 1'b1, 1'b0);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", longint'(o_acc), 0);
    check("arst_beats", longint'(o_beats), 0);
    check("arst_valid", longint'(o_valid), 0);
    check("arst_ready", longint'(o_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    rc = n_results;
    send({24'h0, 8'h38}, {24'h0, 8'h38}, 1'b1, 1'b0);
    send({16'h0, 8'h38, 8'h38}, {16'h0, 8'h38, 8'h38}, 1'b1, 1'b1);
    drain();
    check("t6_count", longint'(n_results - rc), 1);
    check("t6_acc", last_acc, 786432);
    check("t6_beats", longint'(last_beats), 2);

    check("sb_empty", longint'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_acc_fp_lanes.md
Name: mul_acc_fp_lanes

Overview:
- Multi-lane, pipelined minifloat multiply-accumulate engine for MX dot products; successor to the single-product combinational FP multiplier.
- Each accepted beat multiplies LANES operand pairs exactly into fixed-point, sums them through an adder tree and, in accumulate mode, sums beats across a block.
- Valid/ready handshake on both sides with full-pipeline backpressure.
- Sits between the MX operand unpacker and the shared-scale application stage.

Parameters:
EXP_WIDTH, 4, element exponent bits; 0 selects signed two's-complement integer elements
MAN_WIDTH, 3, element mantissa bits (integer magnitude bits minus 1 when EXP_WIDTH=0)
BIT_WIDTH, 1+EXP_WIDTH+MAN_WIDTH, element width
LANES, 4, products per beat (power of 2, >=1)
BLOCK_LEN, 8, max beats per accumulation block (>=1)
PRD_WIDTH, 2*((1<<EXP_WIDTH)+MAN_WIDTH), exact fixed-point lane product width
ACC_WIDTH, PRD_WIDTH+$clog2(LANES)+$clog2(BLOCK_LEN)+1, result width
CNT_WIDTH, $clog2(BLOCK_LEN+1), beat-count width

Ports:
i_clk  in  1  clock (single clock domain)
i_rst_n  in  1  reset, asynchronous assert, active-low
i_valid  in  1  input beat valid
o_ready  out  1  input beat accepted when i_valid&&o_ready
i_op0  in  LANES*BIT_WIDTH  lane k = bits [k*BIT_WIDTH +: BIT_WIDTH]
i_op1  in  LANES*BIT_WIDTH  same packing
i_mode  in  1  0 = per-beat lane sum, 1 = accumulate over block
i_last  in  1  ends the current block early (mode 1 only)
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_acc  out  ACC_WIDTH  signed result
o_beats  out  CNT_WIDTH  number of beats contained in o_acc

Behaviour:
- Reset: o_valid=0, o_acc=0, o_beats=0; all stage valids, accumulator, beat counter and latched mode cleared. o_ready reads 1 out of reset. A reset mid-block discards the partial sum.
- Stall: stall = o_valid && !i_ready. o_ready = !stall. While stalled, every stage, counter and o_acc/o_beats hold. Bubbles (stage valid=0) propagate without affecting accumulator state.
- Lane arithmetic (EXP_WIDTH>0):
  - s = MSB; e = exponent field; nrm = (e!=0); m_ext = {nrm, mantissa}.
  - sm = s ? -m_ext : m_ext, as a signed value of MAN_WIDTH+2 bits.
  - prd = sm0*sm1, shifted left by (e0+e1-nrm0-nrm1), sign-extended to PRD_WIDTH. Exact; no rounding.
  - Subnormals use effective exponent 1. No inf/NaN decode; all encodings are finite.
- EXP_WIDTH=0: prd = signed(op0)*signed(op1), sign-extended to PRD_WIDTH.
- Pipeline (accept at cycle t, no stall):
  - S1 at t+1: decoded signed mantissas, shift amounts and the mantissa products registered.
  - S2 at t+2: shifted lane products summed (sign-extended adder tree) into lane_sum, plus first/last/mode tags.
  - S3 at t+3: accumulator/output register.
- Mode 0: each beat produces a result. o_acc = sign-extended lane_sum, o_beats=1, o_valid at t+3.
- Mode 1: i_mode is latched on a block's first beat; i_mode changes mid-block are ignored until the block closes.
  - First beat loads acc = lane_sum; later beats acc += lane_sum.
  - The block closes on the beat where i_last=1 or the beat count reaches BLOCK_LEN, whichever comes first. That beat's result appears on o_acc with o_beats = count and o_valid at t+3.
  - Next accepted beat starts a new block.
  - i_last is ignored in mode 0.
- Result handshake: o_valid holds, with o_acc/o_beats stable, until i_ready. Same-cycle transfer plus a new S3 result is allowed (o_valid stays 1).
- ACC_WIDTH is sized so accumulation cannot overflow; arithmetic wraps two's complement by construction.
- One beat per cycle throughput when i_ready stays high.

Test Plan:
- Mode 0, LANES=4, all lanes op0=op1=0x38 (E4M3 1.0) -> o_acc=4*262144=1048576, o_beats=1, o_valid exactly 3 cycles after accept.
- Mode 0, lane0 0x01x0x01 (subnormals), lane1 0xB8x0x38, lanes 2-3 zero -> o_acc = 1-262144 = -262143.
- Mode 1, 8 beats of lane0 0x38x0x38, others 0, i_last never asserted -> one result o_acc=2097152, o_beats=8, only after the 8th beat.
- Mode 1, i_last on beat 3, then 2 more beats with i_last on beat 2 -> two results, o_beats=3 then 2, second not polluted by first.
- i_ready low for 5 cycles with continuous i_valid -> o_ready=0 while stalled, o_acc stable, no beat lost or duplicated versus reference model.
- i_rst_n asserted asynchronously after 4 beats of a mode-1 block -> outputs zero immediately; a new 2-beat block after release yields only its own sum.
